mem_load_extract: RTL and testbench
===================================

MEM_LOAD_EXTRACT -- requirements
Module: mem_load_extract

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of ld_addr and mem_addr.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 ld_valid  in  1  load request from core.
REQ-005 ld_ready  out  1  unit can accept a request.
REQ-006 ld_addr  in  ADDR_W  byte address of load.
REQ-007 ld_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes illegal.
REQ-008 mem_req  out  1  word read request to data memory.
REQ-009 mem_addr  out  ADDR_W  word-aligned address, low 2 bits forced 0.
REQ-010 mem_gnt  in  1  memory accepted mem_req this cycle.
REQ-011 mem_rvalid  in  1  mem_rdata valid; arrives one or more cycles after the grant.
REQ-012 mem_rdata  in  32  read word, little-endian byte lanes.
REQ-013 res_valid  out  1  result available.
REQ-014 res_ready  in  1  core consumes result.
REQ-015 res_data  out  32  extracted, extended load value.
REQ-016 res_err  out  1  misaligned or illegal load; qualified by res_valid.

Function
REQ-017 FSM states IDLE, REQ, WAIT, RESP; ld_ready=1 only in IDLE.
REQ-018 IDLE: on ld_valid, latch addr[1:0], funct3 and word address; go to REQ, or go directly to RESP with res_err=1 and res_data=0 when the request is illegal.
REQ-019 Illegal: funct3 not in the legal set; lh/lhu with addr[0]=1; lw with addr[1:0]!=0.
REQ-020 REQ: mem_req=1 with stable mem_addr until mem_gnt; on mem_gnt go to WAIT (mem_gnt and mem_rvalid in the same cycle is not permitted).
REQ-021 WAIT: on mem_rvalid, register the extracted result and go to RESP; mem_req=0.
REQ-022 Byte extract: offset 00/01/10/11 selects rdata[7:0]/[15:8]/[23:16]/[31:24].
REQ-023 Half extract: offset 00 selects rdata[15:0]; offset 10 selects rdata[31:16].
REQ-024 lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word unchanged.
REQ-025 RESP: res_valid=1 with res_data and res_err held stable until res_ready; on res_ready go to IDLE.
REQ-026 Min latency: ld_valid accept -> mem_req next cycle; res_valid the cycle after mem_rvalid.
REQ-027 One outstanding load only; mem_rvalid outside WAIT is ignored.
REQ-028 A new request cannot be accepted in the cycle res_ready is taken (no bypass); the next request is accepted from IDLE.

Reset
REQ-029 rst_n low asynchronously forces IDLE; mem_req=0, res_valid=0, res_err=0, res_data=0, mem_addr=0; ld_ready=1 after release.
REQ-030 Reset mid-transaction abandons the load; a later stray mem_rvalid is ignored per REQ-027.

Structure
REQ-031 A shared package holds the funct3 load-type constants and the FSM state enumeration, reused with the store-side byte-insert logic.
REQ-032 Sub-module load_align_ext (combinational: rdata, offset, funct3 -> 32-bit value) is instantiated once between mem_rdata and the result register.

Verification
REQ-033 lb at addr 0x103, rdata 0x80AABBCC, gnt after 1 cycle, rvalid after 2 cycles -> res_data 0xFFFFFF80, res_err 0.
REQ-034 lbu at addr 0x101, rdata 0x1234F6AA -> res_data 0x000000F6; lhu at addr 0x102 -> 0x00001234.
REQ-035 lh at addr 0x102, rdata 0x8001FFFF -> res_data 0xFFFF8001; lw at addr 0x100 -> 0x8001FFFF.
REQ-036 lw at addr 0x102 -> no mem_req, res_valid next cycle with res_err 1 and res_data 0; funct3 011 -> same response.
REQ-037 res_ready held low for 5 cycles -> res_valid and res_data stable, ld_ready 0; mem_gnt held low for 4 cycles -> mem_req and mem_addr stable.
REQ-038 rst_n asserted while in WAIT -> outputs at reset values immediately; a following rvalid produces no res_valid.

Source files
------------

// File: rtl/mem_load_extract_pkg.sv
// Shared load/store-unit definitions.
// Holds the RISC-V funct3 load-type codes and the load FSM state enumeration.
// The store-side byte-insert logic uses the same codes. load_illegal() decides
// whether a load request can be issued to memory, given its funct3 and the
// byte offset within the word.
package mem_load_extract_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } ld_state_e;

  // Unknown codes and misaligned halfword/word accesses are illegal.
  // Bytes are legal at any offset.
  function automatic logic load_illegal(input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic ill;
    ill = 1'b1;
    case (funct3)
      F3_LB, F3_LBU: ill = 1'b0;
      F3_LH, F3_LHU: ill = offset[0];
      F3_LW:         ill = |offset;
      default:       ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/mem_load_extract_align_ext.sv
// load_align_ext: combinational lane select and extension for loads.
// Ports:
//   rdata  [31:0] : little-endian word from data memory
//   offset [1:0]  : byte offset of the load within the word
//   funct3 [2:0]  : load type (lb/lh/lw/lbu/lhu)
//   value  [31:0] : selected lanes, sign- or zero-extended
// Illegal combinations are filtered out before this block is used.
// For those combinations the output is don't-care.
module load_align_ext
  import mem_load_extract_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Only offsets 00 and 10 are legal for halfwords, so offset[1] is enough.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = rdata;
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LW:   value = rdata;
      F3_LBU:  value = {24'h0, byte_sel};
      F3_LHU:  value = {16'h0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_extract.sv
// mem_load_extract: single-outstanding load unit between core and data memory.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ld_valid/ld_ready     : load request handshake; ld_addr, ld_funct3 are the payload
//   mem_req/mem_gnt       : word read request to memory; mem_addr is word-aligned
//   mem_rvalid/mem_rdata  : read data, one or more cycles after the grant
//   res_valid/res_ready   : result handshake; payload is res_data and res_err
//   dbg_state             : current FSM state, for observation only
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// A source that raises valid keeps it, and its payload, stable until that transfer.
// ld_ready and res_ready may be raised or dropped freely.
// Illegal loads never reach memory. They get an error response with res_data 0.
module mem_load_extract
  import mem_load_extract_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_funct3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_err,
  output ld_state_e         dbg_state
);

  ld_state_e         state, state_nx;
  logic [ADDR_W-1:0] word_addr_q;
  logic [1:0]        offset_q;
  logic [2:0]        funct3_q;
  logic [31:0]       res_data_q;
  logic              res_err_q;
  logic              req_illegal;
  logic [31:0]       ext_value;

  assign req_illegal = load_illegal(ld_funct3, ld_addr[1:0]);

  load_align_ext u_align (
    .rdata  (mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .value  (ext_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request and result registers.
  // Each is written only when its state is left, so it stays stable while
  // mem_req or res_valid is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_addr_q <= '0;
      offset_q    <= '0;
      funct3_q    <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_valid) begin
            word_addr_q <= {ld_addr[ADDR_W-1:2], 2'b00};
            offset_q    <= ld_addr[1:0];
            funct3_q    <= ld_funct3;
            res_err_q   <= req_illegal;
            if (req_illegal) begin
              res_data_q <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            res_data_q <= ext_value;
            res_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    ld_ready  = 1'b0;
    mem_req   = 1'b0;
    res_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          state_nx = req_illegal ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        res_valid = 1'b1;
        // No bypass: the next request is accepted only after IDLE is re-entered.
        if (res_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mem_addr  = word_addr_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_load_extract.sv
module tb_mem_load_extract;
  import mem_load_extract_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  ld_state_e   dbg_state;

  always #5 clk = ~clk;

  mem_load_extract #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_funct3  (ld_funct3),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {err, data} per issued load

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] word;
    int          gd;   // cycles mem_gnt stays low
    int          rd;   // cycles from grant to rvalid (>= 1)
  } mem_item_t;
  mem_item_t mem_q[$];

  bit mem_auto   = 1'b1;
  int hold_ready = 0;
  bit pending    = 1'b0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, computed arithmetically from the load rules.
  function automatic logic [32:0] ref_load(input logic [31:0] addr,
                                           input logic [2:0] f3,
                                           input logic [31:0] word);
    int unsigned off;
    logic [31:0] sh, b, h;
    off = addr % 4;
    sh  = word >> (8 * off);
    b   = sh % 256;
    h   = sh % 65536;
    case (f3)
      3'd0: return {1'b0, (b >= 128) ? b - 32'd256 : b};
      3'd1: if (off % 2 != 0) return {1'b1, 32'h0};
            else return {1'b0, (h >= 32768) ? h - 32'h10000 : h};
      3'd2: if (off != 0) return {1'b1, 32'h0};
            else return {1'b0, word};
      3'd4: return {1'b0, b};
      3'd5: if (off % 2 != 0) return {1'b1, 32'h0};
            else return {1'b0, h};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] word, input int gd, input int rd);
    logic [32:0] e;
    mem_item_t   it;
    int          n;
    e = ref_load(addr, f3, word);
    exp_q.push_back(e);
    if (!e[32]) begin
      it.waddr = addr & 32'hFFFF_FFFC;
      it.word  = word;
      it.gd    = gd;
      it.rd    = rd;
      mem_q.push_back(it);
    end
    @(negedge clk);
    ld_valid  = 1'b1;
    ld_addr   = addr;
    ld_funct3 = f3;
    n = 0;
    while (!ld_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      chk("ld_ready_timeout", 33'(ld_ready), 33'(1));
      ld_valid = 1'b0;
      return;
    end
    @(negedge clk);
    ld_valid  = 1'b0;
    ld_addr   = $urandom;
    ld_funct3 = 3'($urandom_range(0, 7));
    if (!e[32]) begin
      chk("mem_req_latency", 33'(mem_req), 33'(1));
    end else begin
      chk("illegal_no_req", 33'(mem_req), 33'(0));
      chk("illegal_res_latency", 33'(res_valid), 33'(1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending || !ld_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 33'(n < 500), 33'(1));
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_item_t it;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_auto && rst_n && mem_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 33'(mem_req), 33'(0));
        end else begin
          it = mem_q.pop_front();
          chk("mem_addr", 33'(mem_addr), 33'(it.waddr));
          for (int i = 0; i < it.gd; i++) begin
            // Stray rvalid while still requesting must be ignored.
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            @(negedge clk);
            chk("mem_req_hold", 33'(mem_req), 33'(1));
            chk("mem_addr_hold", 33'(mem_addr), 33'(it.waddr));
          end
          mem_rvalid = 1'b0;
          mem_gnt    = 1'b1;
          @(negedge clk);
          mem_gnt = 1'b0;
          chk("mem_req_after_gnt", 33'(mem_req), 33'(0));
          for (int i = 1; i < it.rd; i++) @(negedge clk);
          mem_rvalid = 1'b1;
          mem_rdata  = it.word;
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin
    logic [32:0] e;
    logic [32:0] held;
    res_ready = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending   = 1'b0;
        res_ready = 1'b0;
      end else if (res_valid) begin
        chk("ld_ready_busy", 33'(ld_ready), 33'(0));
        if (!pending) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_res_valid", 33'(res_valid), 33'(0));
          end else begin
            e = exp_q.pop_front();
            chk("res_data", 33'(res_data), 33'(e[31:0]));
            chk("res_err", 33'(res_err), 33'(e[32]));
          end
          held    = {res_err, res_data};
          pending = 1'b1;
        end else begin
          chk("res_hold", {res_err, res_data}, held);
        end
        if (hold_ready > 0) begin
          res_ready = 1'b0;
          hold_ready--;
        end else begin
          res_ready = 1'($urandom_range(0, 1));
        end
        if (res_ready) pending = 1'b0;
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = 32'h0;
    ld_funct3 = 3'b0;
    #3;
    chk("rst_mem_req", 33'(mem_req), 33'(0));
    chk("rst_res_valid", 33'(res_valid), 33'(0));
    chk("rst_res_err", 33'(res_err), 33'(0));
    chk("rst_res_data", 33'(res_data), 33'(0));
    chk("rst_mem_addr", 33'(mem_addr), 33'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", 33'(ld_ready), 33'(1));
    chk("rst_state", 33'(dbg_state), 33'(ST_IDLE));

    // Directed loads
    do_load(32'h103, F3_LB,  32'h80AABBCC, 1, 2);
    do_load(32'h101, F3_LBU, 32'h1234F6AA, 0, 1);
    do_load(32'h102, F3_LHU, 32'h1234F6AA, 0, 1);
    do_load(32'h102, F3_LH,  32'h8001FFFF, 0, 1);
    do_load(32'h100, F3_LW,  32'h8001FFFF, 0, 1);
    drain();
    do_load(32'h102, F3_LW,  32'h11111111, 0, 1);
    drain();
    do_load(32'h100, 3'b011, 32'h22222222, 0, 1);
    drain();
    do_load(32'h101, F3_LH,  32'h33333333, 0, 1);
    drain();
    // Backpressure on result, then a slow grant
    hold_ready = 5;
    do_load(32'h204, F3_LW,  32'hCAFEF00D, 0, 1);
    drain();
    do_load(32'h30A, F3_LH,  32'h7FFF8000, 4, 3);
    drain();

    // Randomized loads
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1)) << 1;
      do_load(a, 3'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3), $urandom_range(1, 3));
    end
    drain();

    // Reset while waiting for read data; later rvalid must be ignored.
    mem_auto = 1'b0;
    @(negedge clk);
    ld_valid  = 1'b1;
    ld_addr   = 32'h0000_0200;
    ld_funct3 = F3_LW;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("rw_mem_req", 33'(mem_req), 33'(1));
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rw_in_wait", 33'(dbg_state), 33'(ST_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("rw_mem_req_rst", 33'(mem_req), 33'(0));
    chk("rw_res_valid_rst", 33'(res_valid), 33'(0));
    chk("rw_res_err_rst", 33'(res_err), 33'(0));
    chk("rw_res_data_rst", 33'(res_data), 33'(0));
    chk("rw_mem_addr_rst", 33'(mem_addr), 33'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rw_no_res", 33'(res_valid), 33'(0));
      chk("rw_ld_ready", 33'(ld_ready), 33'(1));
    end
    mem_auto = 1'b1;

    // Unit still works after the abandoned load.
    do_load(32'h401, F3_LB, 32'h00007F00, 2, 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
